// File: rtl/divider_8_pkg.sv
// Shared types and constants for the divider requester slice.
package divider_8_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DIV0_Q = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    ACKN,
    RESP
  } state_t;

endpackage

// File: rtl/divider_8_watchdog.sv
// Job watchdog: clearable, enabled up-counter that parks at its terminal count.
module divider_8_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic ClkPort,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Parking at LAST keeps tc asserted if a normal transition beat the abort.
  always_ff @(posedge ClkPort) begin
    if (Reset || clr)
      cnt <= '0;
    else if (en && cnt != LAST)
      cnt <= cnt + CW'(1);
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/divider_8_requester.sv
// Requesting side of the PicoBlaze 8-bit divider handshake, with valid/ready
// job and result channels, divide-by-zero rejection and a watchdog abort.
module divider_8_requester
  import divider_8_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic              ClkPort,
  input  logic              Reset,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_x,
  input  logic [DATA_W-1:0] req_y,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_q,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_err_div0,
  output logic              rsp_err_timeout,
  output logic [DATA_W-1:0] Xin,
  output logic [DATA_W-1:0] Yin,
  output logic              Start,
  output logic              Ack,
  input  logic [DATA_W-1:0] Quotient,
  input  logic [DATA_W-1:0] Remainder,
  input  logic              Done,
  input  logic              Qi,
  input  logic              Qc,
  input  logic              Qd,
  output logic [CNT_W-1:0]  jobs_done
);

  state_t            state;
  logic [DATA_W-1:0] x_r, y_r;
  logic              accept, issue_job, wd_en, wd_tc, normal_move;

  assign accept    = (state == IDLE) && req_valid && req_ready;
  assign issue_job = accept && (req_y != '0);
  assign wd_en     = (state == ISSUE) || (state == BUSY) || (state == ACKN);
  assign Xin       = x_r;
  assign Yin       = y_r;

  always_comb begin
    normal_move = 1'b0;
    case (state)
      ISSUE:   normal_move = !Qi;
      BUSY:    normal_move = Done;
      ACKN:    normal_move = Qi;
      default: normal_move = 1'b0;
    endcase
  end

  divider_8_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .clr     (issue_job),
    .en      (wd_en),
    .tc      (wd_tc)
  );

  // req_ready is registered, so it stays low for the first cycle out of reset.
  always_ff @(posedge ClkPort) begin
    if (Reset) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_q           <= '0;
      rsp_r           <= '0;
      rsp_err_div0    <= 1'b0;
      rsp_err_timeout <= 1'b0;
      x_r             <= '0;
      y_r             <= '0;
      Start           <= 1'b0;
      Ack             <= 1'b0;
      jobs_done       <= '0;
    end else if (wd_tc && !normal_move) begin
      Start           <= 1'b0;
      Ack             <= 1'b0;
      rsp_q           <= '0;
      rsp_r           <= '0;
      rsp_err_timeout <= 1'b1;
      rsp_valid       <= 1'b1;
      state           <= RESP;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_y == '0) begin
              rsp_q        <= DIV0_Q;
              rsp_r        <= req_x;
              rsp_err_div0 <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= RESP;
            end else begin
              x_r   <= req_x;
              y_r   <= req_y;
              Start <= 1'b1;
              state <= ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ISSUE: if (!Qi) begin
          Start <= 1'b0;
          state <= BUSY;
        end
        BUSY: if (Done) begin
          rsp_q <= Quotient;
          rsp_r <= Remainder;
          Ack   <= 1'b1;
          state <= ACKN;
        end
        ACKN: if (Qi) begin
          Ack       <= 1'b0;
          jobs_done <= jobs_done + CNT_W'(1);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid       <= 1'b0;
          rsp_err_div0    <= 1'b0;
          rsp_err_timeout <= 1'b0;
          req_ready       <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_state_onehot: assert property (@(posedge ClkPort) disable iff (Reset)
    $onehot({Qi, Qc, Qd}));
  a_start_ack_excl: assert property (@(posedge ClkPort) disable iff (Reset)
    !(Start && Ack));

endmodule
